xbus_arbiter: RTL and testbench
===============================

# xbus_arbiter

Two-master arbiter and access sequencer for the xbus peripheral port. It lets the CPU data port (master 0) and a secondary master (master 1, e.g. a debug or DMA engine) share one xbus slave segment, such as the switch/LED register block. It runs one transaction at a time. Each transaction is a latched address phase, a programmable number of wait cycles, a single-cycle write strobe, registered read data and a one-cycle acknowledge. Ties are broken round-robin.

## Interface
- WAIT_CYCLES, default 0: extra ACCESS cycles before the data cycle. Legal range 0–15.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- m0_req, m1_req  input  1  request; held high until the matching ack.
- m0_we, m1_we  input  1  1 = write, 0 = read.
- m0_be, m1_be  input  4  byte enables.
- m0_addr, m1_addr  input  32  byte address.
- m0_wdata, m1_wdata  input  32  write data.
- m0_rdata, m1_rdata  output  32  read data; valid while ack is high, then held until that master's next ack.
- m0_ack, m1_ack  output  1  one-cycle completion pulse.
- xbus_cs  output  1  slave select.
- xbus_we  output  1  write strobe.
- xbus_be  output  4  latched byte enables.
- xbus_addr  output  32  latched address.
- xbus_wdata  output  32  latched write data.
- xbus_rdata  input  32  slave read data; combinational from the slave.

## Operation
- FSM states: IDLE, ACCESS, DONE. Registers: state, wait counter (4 bits), grant (current owner), last (previous owner), latched we/be/addr/wdata, and one rdata register per master.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one req high: that master wins.
  - Both high: the master not equal to `last` wins.
  - On a win: latch the winner's we/be/addr/wdata, set grant, load counter with WAIT_CYCLES, go to ACCESS.
- **ACCESS**
  - xbus_cs = 1 in every ACCESS cycle.
  - If counter ≠ 0: decrement and stay.
  - If counter = 0 (the data cycle):
    - xbus_we = latched we. xbus_we is 0 in all other cycles, so a write commits exactly once.
    - For a read, capture xbus_rdata into the granted master's rdata register. For a write, leave that master's rdata unchanged.
    - Go to DONE.
- **DONE**
  - Assert ack of the granted master only.
  - Set last = grant.
  - Go to IDLE.
- Outside ACCESS, xbus_cs = xbus_we = 0. xbus_be/addr/wdata hold their last latched values.
- Master rules: drive req and its fields from registers. Deassert req, or present a new transaction, on the edge where ack = 1 is sampled. A req still high in the following IDLE cycle counts as a new request. Fields must stay stable while req is high; the arbiter latches them only in IDLE.
- A request arriving during ACCESS/DONE waits; it is not lost. The other master is never starved: it wins the first IDLE arbitration after any completed transaction.
- xbus_be is forwarded unchanged, including be = 0. Address decoding belongs to the slave.

## Timing
- Reset values:
  - Outputs: xbus_cs/we = 0, xbus_be/addr/wdata = 0, m0/m1_ack = 0, m0/m1_rdata = 0.
  - Internal: state = IDLE, counter = 0, grant = 0, last = 1 (master 0 wins the first tie).
- Reset asserted in any state: at that edge the FSM goes to IDLE. A transaction in progress is aborted with no ack and no write strobe after the edge. rdata registers clear.
- Latency, with req first sampled in IDLE at cycle 0:
  - ACCESS occupies cycles 1 to 1+WAIT_CYCLES.
  - DONE (ack high) is cycle 2+WAIT_CYCLES.
  - Next IDLE is cycle 3+WAIT_CYCLES.
- Throughput: one transaction per 3+WAIT_CYCLES cycles.
- Read data is sampled in the same cycle xbus_we would strobe, i.e. the last ACCESS cycle. It is visible on rdata in the DONE cycle.

## Test plan
- WAIT_CYCLES=0, m0 read of addr 0x10, slave returns 0x00A5_003C → cs high cycle 1 only; we = 0 throughout; m0_ack high cycle 2 with m0_rdata = 0x00A5003C; m1_ack stays 0.
- WAIT_CYCLES=0, m1 write addr 0x10, be = 4'b0001, wdata = 0x0000_00FF → xbus_we high exactly one cycle with addr/be/wdata as given; m1_ack in cycle 2; m1_rdata unchanged.
- Both req high together from reset, each repeating writes → grants alternate m0, m1, m0, m1; each ack 3 cycles apart; first ack is m0_ack.
- m0 issues 4 back-to-back reads, m1 idle → four m0 grants; ack every 3 cycles. m1 raises req during the 2nd transaction → m1 is granted immediately after that transaction's DONE.
- WAIT_CYCLES=2, m0 write → cs high cycles 1–3; we high only in cycle 3; ack in cycle 4.
- WAIT_CYCLES=2, rst pulsed in cycle 2 of an m0 write → cs falls after that edge; no we pulse; no ack; all outputs at reset values; next request gets normal latency.

Source files
------------

// File: rtl/xbus_arbiter.sv
// Two-master round-robin arbiter and single-transaction access sequencer for one xbus slave segment.
// Each grant runs IDLE -> ACCESS (1 + WAIT_CYCLES cycles) -> DONE (ack) -> IDLE.
module xbus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        xbus_cs,
  output logic        xbus_we,
  output logic [3:0]  xbus_be,
  output logic [31:0] xbus_addr,
  output logic [31:0] xbus_wdata,
  input  logic [31:0] xbus_rdata,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a master holds req and its fields stable until it samples its
  // one-cycle ack; fields are only latched in IDLE, so a req still high in the
  // IDLE cycle after ack is a new transaction.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        grant_q;
  logic        last_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] m0_rdata_q;
  logic [31:0] m1_rdata_q;
  logic        cs_q;
  logic        strobe_q;
  logic        m0_ack_q;
  logic        m1_ack_q;

  logic        req_any;
  logic        grant_d;
  logic        we_d;
  logic [3:0]  be_d;
  logic [31:0] addr_d;
  logic [31:0] wdata_d;

  // On a tie the master that did not own the previous transaction wins.
  always_comb begin
    req_any = m0_req | m1_req;
    grant_d = m1_req & (~m0_req | ~last_q);
    we_d    = grant_d ? m1_we    : m0_we;
    be_d    = grant_d ? m1_be    : m0_be;
    addr_d  = grant_d ? m1_addr  : m0_addr;
    wdata_d = grant_d ? m1_wdata : m0_wdata;
  end

  // Outputs are registered: cs/strobe/ack are computed one edge ahead so they
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      be_q       <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
      cs_q       <= 1'b0;
      strobe_q   <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_any) begin
            state_q  <= ST_ACCESS;
            grant_q  <= grant_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= WAIT_LD;
            cs_q     <= 1'b1;
            strobe_q <= we_d & (WAIT_LD == 4'd0);
          end
        end
        ST_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q    <= cnt_q - 4'd1;
            strobe_q <= we_q & (cnt_q == 4'd1);
          end else begin
            state_q  <= ST_DONE;
            cs_q     <= 1'b0;
            strobe_q <= 1'b0;
            if (!we_q) begin
              if (grant_q) m1_rdata_q <= xbus_rdata;
              else         m0_rdata_q <= xbus_rdata;
            end
            m0_ack_q <= ~grant_q;
            m1_ack_q <= grant_q;
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          last_q   <= grant_q;
        end
        default: begin
          state_q  <= ST_IDLE;
          cs_q     <= 1'b0;
          strobe_q <= 1'b0;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign xbus_cs     = cs_q;
  assign xbus_we     = strobe_q;
  assign xbus_be     = be_q;
  assign xbus_addr   = addr_q;
  assign xbus_wdata  = wdata_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign m0_ack      = m0_ack_q;
  assign m1_ack      = m1_ack_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: instance a uses WAIT_CYCLES=0, instance b uses WAIT_CYCLES=2.
// Cycle n below means "observed #1 after the n-th rising edge following request setup".
module tb_xbus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a (WAIT_CYCLES = 0)
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, xbus_cs, xbus_we;
  logic [3:0]  xbus_be;
  logic [31:0] xbus_addr, xbus_wdata, xbus_rdata;
  logic [1:0]  dbg_state;
  logic [31:0] rd_val;
  logic        rd_by_addr;

  // instance b (WAIT_CYCLES = 2)
  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [3:0]  b_m0_be, b_m1_be;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_m0_ack, b_m1_ack, b_xbus_cs, b_xbus_we;
  logic [3:0]  b_xbus_be;
  logic [31:0] b_xbus_addr, b_xbus_wdata, b_xbus_rdata;
  logic [1:0]  b_dbg_state;

  // slave models
  assign xbus_rdata   = rd_by_addr ? (32'hC0DE_0000 | xbus_addr) : rd_val;
  assign b_xbus_rdata = 32'h5A00_0000 | b_xbus_addr;

  int checks = 0;
  int failures = 0;
  int a_we_cnt = 0;
  int b_we_cnt = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    if (xbus_we === 1'b1) a_we_cnt++;
    if (b_xbus_we === 1'b1) b_we_cnt++;
  end

  xbus_arbiter #(.WAIT_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .xbus_cs(xbus_cs), .xbus_we(xbus_we), .xbus_be(xbus_be), .xbus_addr(xbus_addr),
    .xbus_wdata(xbus_wdata), .xbus_rdata(xbus_rdata), .dbg_state_o(dbg_state)
  );

  xbus_arbiter #(.WAIT_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_be(b_m0_be), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_be(b_m1_be), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .xbus_cs(b_xbus_cs), .xbus_we(b_xbus_we), .xbus_be(b_xbus_be), .xbus_addr(b_xbus_addr),
    .xbus_wdata(b_xbus_wdata), .xbus_rdata(b_xbus_rdata), .dbg_state_o(b_dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_be = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_be = 0; b_m1_addr = 0; b_m1_wdata = 0;
    rd_val = 0; rd_by_addr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    checks++; if (xbus_cs !== 1'b0) begin failures++; $display("FAIL rst_cs got=%0h exp=0", xbus_cs); end
    checks++; if (xbus_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", xbus_we); end
    checks++; if (xbus_be !== 4'h0) begin failures++; $display("FAIL rst_be got=%0h exp=0", xbus_be); end
    checks++; if (xbus_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", xbus_addr); end
    checks++; if (xbus_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%0h exp=0", xbus_wdata); end
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL rst_ack got=%0b exp=00", {m0_ack, m1_ack}); end
    checks++; if (m0_rdata !== 32'h0) begin failures++; $display("FAIL rst_m0_rdata got=%0h exp=0", m0_rdata); end
    checks++; if (m1_rdata !== 32'h0) begin failures++; $display("FAIL rst_m1_rdata got=%0h exp=0", m1_rdata); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0h exp=0", dbg_state); end
    checks++; if ({b_xbus_cs, b_xbus_we, b_m0_ack, b_m1_ack} !== 4'h0) begin failures++; $display("FAIL rst_b_ctrl got=%0h exp=0", {b_xbus_cs, b_xbus_we, b_m0_ack, b_m1_ack}); end
    rst = 0;
  endtask

  task automatic test_read_m0();
    int we0;
    we0 = a_we_cnt;
    rd_by_addr = 0; rd_val = 32'h00A5_003C;
    m0_we = 0; m0_be = 4'hF; m0_addr = 32'h10; m0_wdata = 32'h0; m0_req = 1;
    tick(); // cycle 1
    checks++; if (xbus_cs !== 1'b1) begin failures++; $display("FAIL rd_cs_c1 got=%0h exp=1", xbus_cs); end
    checks++; if (xbus_addr !== 32'h10) begin failures++; $display("FAIL rd_addr_c1 got=%0h exp=10", xbus_addr); end
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_c1 got=%0h exp=0", m0_ack); end
    tick(); // cycle 2
    checks++; if (xbus_cs !== 1'b0) begin failures++; $display("FAIL rd_cs_c2 got=%0h exp=0", xbus_cs); end
    checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL rd_m0_ack_c2 got=%0h exp=1", m0_ack); end
    checks++; if (m1_ack !== 1'b0) begin failures++; $display("FAIL rd_m1_ack_c2 got=%0h exp=0", m1_ack); end
    checks++; if (m0_rdata !== 32'h00A5_003C) begin failures++; $display("FAIL rd_data got=%0h exp=a5003c", m0_rdata); end
    m0_req = 0; rd_val = 32'h1234_5678;
    tick(); // cycle 3
    checks++; if (m0_ack !== 1'b0) begin failures++; $display("FAIL rd_ack_c3 got=%0h exp=0", m0_ack); end
    checks++; if (m0_rdata !== 32'h00A5_003C) begin failures++; $display("FAIL rd_data_hold got=%0h exp=a5003c", m0_rdata); end
    checks++; if (a_we_cnt - we0 !== 0) begin failures++; $display("FAIL rd_we_pulses got=%0d exp=0", a_we_cnt - we0); end
  endtask

  task automatic test_write_m1();
    int we0;
    we0 = a_we_cnt;
    rd_val = 32'hFFFF_FFFF;
    m1_we = 1; m1_be = 4'b0001; m1_addr = 32'h10; m1_wdata = 32'h0000_00FF; m1_req = 1;
    tick(); // cycle 1
    checks++; if (xbus_we !== 1'b1) begin failures++; $display("FAIL wr_we_c1 got=%0h exp=1", xbus_we); end
    checks++; if (xbus_be !== 4'b0001) begin failures++; $display("FAIL wr_be got=%0h exp=1", xbus_be); end
    checks++; if (xbus_addr !== 32'h10) begin failures++; $display("FAIL wr_addr got=%0h exp=10", xbus_addr); end
    checks++; if (xbus_wdata !== 32'hFF) begin failures++; $display("FAIL wr_wdata got=%0h exp=ff", xbus_wdata); end
    tick(); // cycle 2
    checks++; if (xbus_we !== 1'b0) begin failures++; $display("FAIL wr_we_c2 got=%0h exp=0", xbus_we); end
    checks++; if ({m0_ack, m1_ack} !== 2'b01) begin failures++; $display("FAIL wr_ack_c2 got=%0b exp=01", {m0_ack, m1_ack}); end
    checks++; if (m1_rdata !== 32'h0) begin failures++; $display("FAIL wr_m1_rdata got=%0h exp=0", m1_rdata); end
    m1_req = 0;
    tick(); // cycle 3
    checks++; if (a_we_cnt - we0 !== 1) begin failures++; $display("FAIL wr_we_pulses got=%0d exp=1", a_we_cnt - we0); end
  endtask

  task automatic test_alternate();
    int we0;
    logic exp0, exp1;
    logic [31:0] exp_addr;
    do_reset();
    we0 = a_we_cnt;
    m0_we = 1; m0_be = 4'hF; m0_addr = 32'h20; m0_wdata = 32'h1111_1111;
    m1_we = 1; m1_be = 4'h3; m1_addr = 32'h24; m1_wdata = 32'h2222_2222;
    m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp0 = (c % 3 == 2) && ((c / 3) % 2 == 0);
      exp1 = (c % 3 == 2) && ((c / 3) % 2 == 1);
      checks++; if (m0_ack !== exp0) begin failures++; $display("FAIL alt_m0_ack c=%0d got=%0h exp=%0h", c, m0_ack, exp0); end
      checks++; if (m1_ack !== exp1) begin failures++; $display("FAIL alt_m1_ack c=%0d got=%0h exp=%0h", c, m1_ack, exp1); end
      if (c % 3 == 1) begin
        exp_addr = ((c / 3) % 2 == 0) ? 32'h20 : 32'h24;
        checks++; if (xbus_addr !== exp_addr) begin failures++; $display("FAIL alt_addr c=%0d got=%0h exp=%0h", c, xbus_addr, exp_addr); end
      end
    end
    m0_req = 0; m1_req = 0;
    tick();
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL alt_idle got=%0h exp=0", dbg_state); end
    checks++; if (a_we_cnt - we0 !== 4) begin failures++; $display("FAIL alt_we_pulses got=%0d exp=4", a_we_cnt - we0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic exp0, exp1;
    logic [31:0] exp_d;
    rd_by_addr = 1;
    m0_we = 0; m0_be = 4'hF; m0_addr = 32'h100; m0_req = 1;
    m1_we = 0; m1_be = 4'hF; m1_addr = 32'h200; m1_req = 0;
    exp_q = {};
    exp_q.push_back(32'hC0DE_0100);
    exp_q.push_back(32'hC0DE_0104);
    exp_q.push_back(32'hC0DE_0108);
    exp_q.push_back(32'hC0DE_010C);
    n0 = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp0 = (c == 2) || (c == 5) || (c == 11) || (c == 14);
      exp1 = (c == 8);
      checks++; if (m0_ack !== exp0) begin failures++; $display("FAIL b2b_m0_ack c=%0d got=%0h exp=%0h", c, m0_ack, exp0); end
      checks++; if (m1_ack !== exp1) begin failures++; $display("FAIL b2b_m1_ack c=%0d got=%0h exp=%0h", c, m1_ack, exp1); end
      if (m0_ack === 1'b1 && exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        checks++; if (m0_rdata !== exp_d) begin failures++; $display("FAIL b2b_m0_rdata c=%0d got=%0h exp=%0h", c, m0_rdata, exp_d); end
        n0++;
        if (n0 == 4) m0_req = 0;
        else m0_addr = 32'h100 + 32'(4 * n0);
      end
      if (m1_ack === 1'b1) begin
        checks++; if (m1_rdata !== 32'hC0DE_0200) begin failures++; $display("FAIL b2b_m1_rdata got=%0h exp=c0de0200", m1_rdata); end
        m1_req = 0;
      end
      if (c == 4) m1_req = 1;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing_acks got=%0d exp=0", exp_q.size()); end
    m0_req = 0; m1_req = 0;
  endtask

  task automatic test_wait2();
    int wb0;
    logic exp_cs, exp_we, exp_ack;
    do_reset();
    wb0 = b_we_cnt;
    b_m0_we = 1; b_m0_be = 4'hF; b_m0_addr = 32'h30; b_m0_wdata = 32'hDEAD_BEEF; b_m0_req = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_cs = (c >= 1) && (c <= 3);
      exp_we = (c == 3);
      exp_ack = (c == 4);
      checks++; if (b_xbus_cs !== exp_cs) begin failures++; $display("FAIL w2_cs c=%0d got=%0h exp=%0h", c, b_xbus_cs, exp_cs); end
      checks++; if (b_xbus_we !== exp_we) begin failures++; $display("FAIL w2_we c=%0d got=%0h exp=%0h", c, b_xbus_we, exp_we); end
      checks++; if (b_m0_ack !== exp_ack) begin failures++; $display("FAIL w2_ack c=%0d got=%0h exp=%0h", c, b_m0_ack, exp_ack); end
      if (c == 3) begin
        checks++; if (b_xbus_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL w2_wdata got=%0h exp=deadbeef", b_xbus_wdata); end
      end
      if (c == 4) b_m0_req = 0;
    end
    checks++; if (b_we_cnt - wb0 !== 1) begin failures++; $display("FAIL w2_we_pulses got=%0d exp=1", b_we_cnt - wb0); end
  endtask

  task automatic test_reset_abort();
    int wb0;
    logic exp_cs, exp_ack;
    wb0 = b_we_cnt;
    b_m0_we = 1; b_m0_be = 4'hA; b_m0_addr = 32'h34; b_m0_wdata = 32'hCAFE_F00D; b_m0_req = 1;
    tick(); // cycle 1
    checks++; if (b_xbus_cs !== 1'b1) begin failures++; $display("FAIL ab_cs_c1 got=%0h exp=1", b_xbus_cs); end
    tick(); // cycle 2
    checks++; if (b_xbus_we !== 1'b0) begin failures++; $display("FAIL ab_we_c2 got=%0h exp=0", b_xbus_we); end
    rst = 1; b_m0_req = 0;
    tick();
    checks++; if ({b_xbus_cs, b_xbus_we, b_m0_ack, b_m1_ack} !== 4'h0) begin failures++; $display("FAIL ab_ctrl got=%0h exp=0", {b_xbus_cs, b_xbus_we, b_m0_ack, b_m1_ack}); end
    checks++; if ({b_xbus_be, b_xbus_addr, b_xbus_wdata} !== 68'h0) begin failures++; $display("FAIL ab_fields got=%0h exp=0", {b_xbus_be, b_xbus_addr, b_xbus_wdata}); end
    checks++; if (b_dbg_state !== 2'd0) begin failures++; $display("FAIL ab_state got=%0h exp=0", b_dbg_state); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin failures++; $display("FAIL ab_rdata_clear got=%0h exp=0", {m0_rdata, m1_rdata}); end
    rst = 0;
    tick();
    tick();
    checks++; if (b_m0_ack !== 1'b0) begin failures++; $display("FAIL ab_no_ack got=%0h exp=0", b_m0_ack); end
    checks++; if (b_we_cnt - wb0 !== 0) begin failures++; $display("FAIL ab_we_pulses got=%0d exp=0", b_we_cnt - wb0); end
    b_m0_we = 0; b_m0_be = 4'hF; b_m0_addr = 32'h40; b_m0_req = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_cs = (c >= 1) && (c <= 3);
      exp_ack = (c == 4);
      checks++; if (b_xbus_cs !== exp_cs) begin failures++; $display("FAIL ab_rd_cs c=%0d got=%0h exp=%0h", c, b_xbus_cs, exp_cs); end
      checks++; if (b_m0_ack !== exp_ack) begin failures++; $display("FAIL ab_rd_ack c=%0d got=%0h exp=%0h", c, b_m0_ack, exp_ack); end
      if (c == 4) begin
        checks++; if (b_m0_rdata !== 32'h5A00_0040) begin failures++; $display("FAIL ab_rd_data got=%0h exp=5a000040", b_m0_rdata); end
        b_m0_req = 0;
      end
    end
    checks++; if (b_we_cnt - wb0 !== 0) begin failures++; $display("FAIL ab_rd_we_pulses got=%0d exp=0", b_we_cnt - wb0); end
  endtask

  initial begin
    test_reset();
    test_read_m0();
    test_write_m1();
    test_alternate();
    test_back_to_back();
    test_wait2();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
